// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared types, constants and helpers for the clock step controller
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } state_t;

  localparam int MIN_DIVISOR   = 1;
  localparam int MAX_DIV_WIDTH = 64;

  // A zero divisor would never reach a boundary, so it is treated as the fastest legal rate.
  function automatic logic [MAX_DIV_WIDTH-1:0] clamp_divisor(input logic [MAX_DIV_WIDTH-1:0] d);
    if (d == '0) begin
      return MAX_DIV_WIDTH'(MIN_DIVISOR);
    end
    return d;
  endfunction

endpackage

// File: rtl/period_counter.sv
// rtl/period_counter.sv - programmable 0..D-1 period counter with boundary and phase flags
module period_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] count,
  output logic             boundary,
  output logic             phase_high
);

  assign boundary   = enable && (count == (divisor - WIDTH'(1)));
  assign phase_high = (count >= (divisor >> 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || boundary) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_step_controller.sv
// rtl/clock_step_controller.sv - run/stop/single-step divided clock and tick generator
module clock_step_controller
  import clock_ctrl_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter int unsigned RESET_DIVISOR = 2
) (
  input  logic             i_SYS_CLOCK,
  input  logic             i_RESET,
  input  logic             i_RUN,
  input  logic             i_STEP,
  input  logic             i_DIV_VALID,
  input  logic [WIDTH-1:0] i_DIV_DATA,
  output logic             o_DIV_READY,
  output logic             o_CLOCK,
  output logic             o_TICK,
  output logic             o_RUNNING,
  output logic [WIDTH-1:0] o_DIVISOR
);

  localparam logic [WIDTH-1:0] INIT_DIVISOR =
    WIDTH'(clamp_divisor(MAX_DIV_WIDTH'(RESET_DIVISOR)));

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] count;
  logic             counting;
  logic             boundary;
  logic             phase_high;
  logic             transfer;
  logic             apply;

  assign counting = (state != STOPPED);
  assign transfer = i_DIV_VALID && o_DIV_READY;
  // A new divisor only lands at a period start, so no period mixes two divisors.
  assign apply    = !o_DIV_READY && (counting ? boundary : (count == '0));

  period_counter #(
    .WIDTH(WIDTH)
  ) u_period_counter (
    .clk        (i_SYS_CLOCK),
    .rst        (i_RESET),
    .enable     (counting),
    .clear      (!counting),
    .divisor    (o_DIVISOR),
    .count      (count),
    .boundary   (boundary),
    .phase_high (phase_high)
  );

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state     <= STOPPED;
      o_RUNNING <= 1'b0;
      o_CLOCK   <= 1'b0;
      o_TICK    <= 1'b0;
    end else begin
      o_TICK  <= boundary;
      o_CLOCK <= counting && phase_high;
      case (state)
        STOPPED: begin
          if (i_RUN) begin
            state     <= RUNNING;
            o_RUNNING <= 1'b1;
          end else if (i_STEP) begin
            state     <= STEPPING;
            o_RUNNING <= 1'b1;
          end
        end
        RUNNING: begin
          if (boundary && !i_RUN) begin
            state     <= STOPPED;
            o_RUNNING <= 1'b0;
          end
        end
        STEPPING: begin
          if (boundary) begin
            if (i_RUN) begin
              state <= RUNNING;
            end else begin
              state     <= STOPPED;
              o_RUNNING <= 1'b0;
            end
          end
        end
        default: begin
          state     <= STOPPED;
          o_RUNNING <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      o_DIV_READY <= 1'b1;
      o_DIVISOR   <= INIT_DIVISOR;
      pending     <= '0;
    end else if (apply) begin
      o_DIVISOR   <= pending;
      o_DIV_READY <= 1'b1;
    end else if (transfer) begin
      pending     <= WIDTH'(clamp_divisor(MAX_DIV_WIDTH'(i_DIV_DATA)));
      o_DIV_READY <= 1'b0;
    end
  end

endmodule
